// File: rtl/mem_arbiter_if.sv
// Memory request/response bundle shared by the instruction port, the data port
// and the physical memory side of mem_arbiter.
interface mem_arbiter_if;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  byte_enable;
  logic [15:0] rdata;
  logic        resp;

  // The requester drives the strobes; the responder returns data and completion.
  modport master (
    output read, write, addr, wdata, byte_enable,
    input  rdata, resp
  );

  modport slave (
    input  read, write, addr, wdata, byte_enable,
    output rdata, resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter (instruction and data ports) in front of one physical memory.
// The winning request is latched on grant so client changes never reach memory.
//
// state   | meaning
// IDLE    | no transaction; sample client strobes and pick a winner
// GRANT_I | instruction request latched and driven to memory; wait for pmem resp
// GRANT_D | data request latched and driven to memory; wait for pmem resp
// DONE    | one-cycle resp pulse to the granted client, then back to IDLE
module mem_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  inst,
  mem_arbiter_if.slave  data,
  mem_arbiter_if.master pmem
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t      state, state_nxt;
  logic        inst_req, data_req;
  logic        grant_i, grant_d;
  logic        granted;
  logic        owner_data;
  logic        req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic [15:0] inst_rdata_q, data_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    inst_req  = inst.read | inst.write;
    data_req  = data.read | data.write;
    case (state)
      IDLE: begin
        if (inst_req && data_req) begin
          grant_d = DATA_PRIO;
          grant_i = !DATA_PRIO;
        end else begin
          grant_i = inst_req;
          grant_d = data_req;
        end
        if (grant_i) begin
          state_nxt = GRANT_I;
        end else if (grant_d) begin
          state_nxt = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem.resp) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read+write together from a client is treated as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_data   <= 1'b0;
      req_write    <= 1'b0;
      req_addr     <= 16'h0000;
      req_wdata    <= 16'h0000;
      req_be       <= 2'b00;
      inst_rdata_q <= 16'h0000;
      data_rdata_q <= 16'h0000;
    end else begin
      if (grant_i) begin
        owner_data <= 1'b0;
        req_write  <= inst.write;
        req_addr   <= inst.addr;
        req_wdata  <= inst.wdata;
        req_be     <= inst.byte_enable;
      end else if (grant_d) begin
        owner_data <= 1'b1;
        req_write  <= data.write;
        req_addr   <= data.addr;
        req_wdata  <= data.wdata;
        req_be     <= data.byte_enable;
      end
      if (state == GRANT_I && pmem.resp && !req_write) begin
        inst_rdata_q <= pmem.rdata;
      end
      if (state == GRANT_D && pmem.resp && !req_write) begin
        data_rdata_q <= pmem.rdata;
      end
    end
  end

  assign granted          = (state == GRANT_I) || (state == GRANT_D);
  assign pmem.read        = granted && !req_write;
  assign pmem.write       = granted && req_write;
  assign pmem.byte_enable = granted ? req_be : 2'b00;
  assign pmem.addr        = req_addr;
  assign pmem.wdata       = req_wdata;

  assign inst.resp  = (state == DONE) && !owner_data;
  assign data.resp  = (state == DONE) && owner_data;
  assign inst.rdata = inst_rdata_q;
  assign data.rdata = data_rdata_q;

endmodule
